// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
//   loader_state_t : FSM state encoding
//   INSTR_W        : instruction word width
//   LEN_W          : width of the image length field in the byte stream
package imem_loader_pkg;

    localparam int INSTR_W = 16;
    localparam int LEN_W   = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        WORD_HI,
        WORD_LO,
        WRITE,
        CHECK,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader: loads a program image from a byte stream into instruction memory.
//   Stream: length N (16 bits, MSB first), then N 16-bit words (MSB first),
//   then an 8-bit modulo-256 checksum of the payload bytes when the build
//   defines IMEM_LOADER_CHECKSUM_EN.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start               : pulse that begins a load (honoured in IDLE/DONE/ERR)
//   rx_data/rx_valid    : incoming byte and its valid flag
//   rx_ready            : loader accepts a byte this cycle
//   imem_wren/address/data : one-cycle write port to instruction memory
//   cpu_hold            : holds the CPU in reset while loading or after an error
//   done / error        : sticky completion / abort flags
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_wren,
    output logic [ADDR_W-1:0]  imem_address,
    output logic [INSTR_W-1:0] imem_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(IMEM_DEPTH);

    loader_state_t      state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic               rx_ready_q, rx_ready_d;
    logic               wren_q, wren_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic               xfer;
    logic               start_ok;
    logic [LEN_W-1:0]   n_full;

    assign xfer     = rx_valid && rx_ready_q;
    assign start_ok = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign n_full   = {len_q[LEN_W-1:8], rx_data};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[LEN_W-1:8] = rx_data;
                    state_d          = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = rx_data;
                    if (n_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else if ({1'b0, n_full} > DEPTH_L) begin
                        state_d = ERR;
                    end else begin
                        state_d = WORD_HI;
                    end
                end
            end
            WORD_HI: begin
                if (xfer) begin
                    data_d[15:8] = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d        = sum_q + rx_data;
`endif
                    state_d      = WORD_LO;
                end
            end
            WORD_LO: begin
                if (xfer) begin
                    data_d[7:0] = rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + rx_data;
`endif
                    // Write strobe and address are registered on entry so they
                    // are valid for exactly the one WRITE cycle.
                    wren_d      = 1'b1;
                    addr_d      = cnt_q;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_d == ADDR_W'(len_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = WORD_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    state_d = (rx_data == sum_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Status flags follow the current state, so completion becomes visible
        // one cycle after entering DONE; a start clears them immediately.
        if (start_ok) begin
            hold_d  = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else if (state_q == DONE) begin
            hold_d  = 1'b0;
            done_d  = 1'b1;
        end else if (state_q == ERR) begin
            hold_d  = 1'b1;
            error_d = 1'b1;
        end

        rx_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                     (state_d == WORD_HI) || (state_d == WORD_LO) ||
                     (state_d == CHECK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rx_ready_q <= 1'b0;
            wren_q     <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rx_ready_q <= rx_ready_d;
            wren_q     <= wren_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_wren    = wren_q;
    assign imem_address = addr_q;
    assign imem_data    = data_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for imem_loader.
// Honours IMEM_LOADER_CHECKSUM_EN by appending checksum bytes to each image.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_wren;
    logic [15:0] imem_address;
    logic [15:0] imem_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [15:0] wr_addr [64];
    logic [15:0] wr_data [64];
    logic        wr_rdy  [64];
    int          wr_n = 0;
    int          n0;

    imem_loader #(.IMEM_DEPTH(256), .ADDR_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_wren    (imem_wren),
        .imem_address (imem_address),
        .imem_data    (imem_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_wren) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = imem_address;
                wr_data[wr_n] = imem_data;
                wr_rdy[wr_n]  = rx_ready;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 100) begin
            @(negedge clk);
            waited = waited + 1;
        end
        if (!rx_ready) begin
            check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_cks(input logic [7:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(s, 0);
`else
        if (s == 8'hFF) rx_data = s;  // no checksum byte in this build
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check_eq({tag, "_wren"},     32'(imem_wren), 32'd0);
        check_eq({tag, "_hold"},     32'(cpu_hold), 32'd0);
        check_eq({tag, "_done"},     32'(done), 32'd0);
        check_eq({tag, "_error"},    32'(error), 32'd0);
        check_eq({tag, "_addr"},     32'(imem_address), 32'd0);
        check_eq({tag, "_data"},     32'(imem_data), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_idle_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        // Two-word image 00 02 A1 23 4B 5C
        n0 = wr_n;
        pulse_start();
        check_eq("t1_hold_start", 32'(cpu_hold), 32'd1);
        check_eq("t1_ready_start", 32'(rx_ready), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hA1, 0);
        send_byte(8'h23, 0);
        send_byte(8'h4B, 0);
        send_byte(8'h5C, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        check_eq("t1_wren_k1", 32'(imem_wren), 32'd1);
        check_eq("t1_addr_k1", 32'(imem_address), 32'd1);
        check_eq("t1_done_k1", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("t1_done_k2m", 32'(done), 32'd0);
        check_eq("t1_hold_k2m", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check_eq("t1_done_k2", 32'(done), 32'd1);
        check_eq("t1_hold_k2", 32'(cpu_hold), 32'd0);
`else
        send_cks(8'h6B);
        repeat (3) @(negedge clk);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_hold", 32'(cpu_hold), 32'd0);
`endif
        check_eq("t1_nwr", 32'(wr_n - n0), 32'd2);
        check_eq("t1_a0", 32'(wr_addr[n0]), 32'h0);
        check_eq("t1_d0", 32'(wr_data[n0]), 32'hA123);
        check_eq("t1_a1", 32'(wr_addr[n0+1]), 32'h1);
        check_eq("t1_d1", 32'(wr_data[n0+1]), 32'h4B5C);

        // Empty image 00 00
        n0 = wr_n;
        pulse_start();
        check_eq("t2_hold_start", 32'(cpu_hold), 32'd1);
        check_eq("t2_done_start", 32'(done), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_cks(8'h00);
        repeat (3) @(negedge clk);
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_hold", 32'(cpu_hold), 32'd0);
        check_eq("t2_nwr", 32'(wr_n - n0), 32'd0);

        // Oversize image 01 01 (N=257 > 256)
        n0 = wr_n;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        check_eq("t3_error", 32'(error), 32'd1);
        check_eq("t3_hold", 32'(cpu_hold), 32'd1);
        check_eq("t3_ready", 32'(rx_ready), 32'd0);
        check_eq("t3_done", 32'(done), 32'd0);
        check_eq("t3_nwr", 32'(wr_n - n0), 32'd0);

        // Gapped stream 00 01 12 34, starting from ERR
        n0 = wr_n;
        pulse_start();
        check_eq("t4_error_clr", 32'(error), 32'd0);
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h46, 1);
`endif
        repeat (3) @(negedge clk);
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_nwr", 32'(wr_n - n0), 32'd1);
        check_eq("t4_a0", 32'(wr_addr[n0]), 32'h0);
        check_eq("t4_d0", 32'(wr_data[n0]), 32'h1234);
        check_eq("t4_rdy_wr", 32'(wr_rdy[n0]), 32'd0);

        // Reset after 3 payload bytes of a 4-word image
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        #2;
        reset = 1'b1;
        #1;
        check_idle_zero("t5_rst");
        @(negedge clk);
        reset = 1'b0;
        n0 = wr_n;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_cks(8'h78);
        repeat (3) @(negedge clk);
        check_eq("t5_done", 32'(done), 32'd1);
        check_eq("t5_nwr", 32'(wr_n - n0), 32'd1);
        check_eq("t5_a0", 32'(wr_addr[n0]), 32'h0);
        check_eq("t5_d0", 32'(wr_data[n0]), 32'hABCD);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum 00 01 12 34 47
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h47, 0);
        repeat (3) @(negedge clk);
        check_eq("cks_bad_error", 32'(error), 32'd1);
        check_eq("cks_bad_done", 32'(done), 32'd0);
        check_eq("cks_bad_hold", 32'(cpu_hold), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader and writer for the instruction ROM/RAM that the fetch stage reads.
- Accepts a byte stream (host link, e.g. UART RX) using a valid/ready handshake.
- Assembles 16-bit instruction words and writes them sequentially from address 0.
- Holds the CPU pipeline in reset while loading and releases it once the image is complete.

Parameters:
- IMEM_DEPTH, 256, number of 16-bit words in instruction memory; maximum accepted image length.
- ADDR_W, 16, width of the instruction memory address. It matches the PC width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- imem_wren  out  1  instruction memory write enable
- imem_address  out  ADDR_W  instruction memory write address
- imem_data  out  16  instruction word to write
- cpu_hold  out  1  drives the CPU reset while high
- done  out  1  image loaded successfully (sticky)
- error  out  1  load aborted (sticky)

Behaviour:
- Interface:
  - One clock, clk.
  - reset is asynchronous and active-high.
  - Every flop clears on reset assertion, independent of clk.
- Reset values:
  - State is IDLE.
  - rx_ready, imem_wren, cpu_hold, done and error are 0.
  - imem_address and imem_data are 0.
  - The word counter and the length register are 0.
- Byte acceptance:
  - A byte transfers on a rising clk edge where rx_valid and rx_ready are both 1.
  - rx_ready is 1 only in LEN_HI, LEN_LO, WORD_HI, WORD_LO and CHECK.
  - rx_ready is a registered function of state. It does not depend combinationally on rx_valid.
- Stream format:
  - Length N, high byte first.
  - Then N words, each sent high byte first.
  - Then the checksum byte, only when the optional feature is enabled.
- FSM states and transitions:
  - IDLE: on start go to LEN_HI and set cpu_hold=1, done=0, error=0.
  - LEN_HI: on transfer, latch N[15:8] and go to LEN_LO.
  - LEN_LO: on transfer, latch N[7:0]. Then:
    - If N==0, go to DONE (or CHECK when the feature is enabled).
    - If N>IMEM_DEPTH, go to ERR.
    - Otherwise go to WORD_HI.
  - WORD_HI: on transfer, latch imem_data[15:8] and go to WORD_LO.
  - WORD_LO: on transfer, latch imem_data[7:0] and go to WRITE.
  - WRITE: for exactly one cycle, drive imem_wren=1 with imem_address = word counter.
    - Increment the counter.
    - If the counter has reached N, go to DONE (or CHECK). Otherwise go to WORD_HI.
  - DONE: done=1 and cpu_hold=0. Go to LEN_HI on start.
  - ERR: error=1 and cpu_hold=1. Leave only on start (to LEN_HI) or on reset.
- start outside IDLE, DONE or ERR is ignored. A load in progress is never restarted.
- Latency:
  - The last byte is accepted at edge k.
  - imem_wren is high during cycle k+1.
  - done=1 and cpu_hold=0 take effect from edge k+2.
- imem_address holds its last value when imem_wren is 0.
- Gaps in rx_valid may be arbitrary length. State is held and no timeout is applied.
- Reset mid-load: the partial image stays in memory. cpu_hold drops to 0, so the CPU runs whatever is in the ROM.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - A CHECK state follows the final WRITE, or follows LEN_LO when N==0.
  - CHECK accepts one byte.
  - It is compared with the 8-bit modulo-256 sum of all payload word bytes. Length bytes are excluded.
  - Match goes to DONE; mismatch goes to ERR.
  - The running sum clears on start.
- Disabled: no CHECK state and no checksum register. The last WRITE goes directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum loader_state_t (IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, CHECK, DONE, ERR);
  - the constant INSTR_W=16.
- No sub-module is needed. The FSM, counter and byte assembly are one module.

Test Plan:
- Reset, then start, then bytes 00 02 A1 23 4B 5C:
  - writes 0xA123 to address 0 and 0x4B5C to address 1, with exactly 2 imem_wren pulses;
  - done=1 and cpu_hold=0 two cycles after the last byte.
- Start, then bytes 00 00: no imem_wren; done=1; cpu_hold returns to 0.
- Start, then bytes 01 01 with IMEM_DEPTH=256: error=1, cpu_hold stays 1, and rx_ready=0 afterwards.
- Bytes 00 01 12 34 sent with rx_valid toggling every other cycle: a single write of 0x1234 to address 0, and rx_ready=0 during WRITE.
- Reset asserted after 3 payload bytes of a 4-word image:
  - all outputs are 0 asynchronously;
  - a following start with a 1-word image writes address 0.
- With IMEM_LOADER_CHECKSUM_EN:
  - bytes 00 01 12 34 46 give done=1;
  - bytes 00 01 12 34 47 give error=1.
